// File: rtl/src_fetch.sv
// src_fetch: Wishbone read master that streams a contiguous buffer of 64-bit words
// into the source FIFO, one outstanding read at a time, tagging the final word.
module src_fetch #(
    parameter int unsigned AW   = 32,
    parameter int unsigned LENW = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [LENW-1:0] src_len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   wbm_adr_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [7:0]      wbm_sel_o,
    input  logic [63:0]     wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic            f_putn,
    output logic [63:0]     f_dat,
    output logic            f_last,
    input  logic            f_full,
    input  logic            f_almost_full
);
    typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_e;

    state_e          r_state, w_state_nxt;
    logic [AW-1:0]   r_adr, w_adr_nxt;
    logic [LENW-1:0] r_rem, w_rem_nxt;
    logic [63:0]     r_dat, w_dat_nxt;
    logic            r_putn, w_putn_nxt;
    logic            r_last, w_last_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;
    logic            w_req;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
            r_adr   <= '0;
            r_rem   <= '0;
            r_dat   <= '0;
            r_putn  <= 1'b1;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_rem   <= w_rem_nxt;
            r_dat   <= w_dat_nxt;
            r_putn  <= w_putn_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_rem_nxt   = r_rem;
        w_dat_nxt   = r_dat;
        w_putn_nxt  = 1'b1;
        w_last_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_err_nxt = 1'b0;
                    if (src_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_adr_nxt   = {src_addr[AW-1:3], 3'b000};
                        w_rem_nxt   = src_len;
                        // Only request when the FIFO can take this word and the next.
                        w_state_nxt = f_almost_full ? StHold : StReq;
                    end
                end
            end
            StReq: begin
                if (wbm_err_i) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StErr;
                end else if (wbm_ack_i) begin
                    w_putn_nxt = 1'b0;
                    w_dat_nxt  = wbm_dat_i;
                    w_rem_nxt  = r_rem - LENW'(1);
                    if (r_rem == LENW'(1)) begin
                        w_last_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_adr_nxt   = r_adr + AW'(8);
                        w_state_nxt = f_almost_full ? StHold : StReq;
                    end
                end
            end
            StHold: begin
                if (!f_almost_full) begin
                    w_state_nxt = StReq;
                end
            end
            StErr: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign w_req     = (r_state == StReq);
    assign busy      = w_req || (r_state == StHold);
    assign done      = r_done;
    assign err       = r_err;
    assign wbm_adr_o = r_adr;
    assign wbm_cyc_o = w_req;
    assign wbm_stb_o = w_req;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 8'hFF;
    assign f_putn    = r_putn;
    assign f_dat     = r_dat;
    assign f_last    = r_last;

    a_no_push_when_full: assert property (
        @(posedge wb_clk_i) disable iff (wb_rst_i) !f_putn |-> !f_full
    );

endmodule

// File: tb/tb_src_fetch.sv
// tb_src_fetch: table-driven and randomized checks of src_fetch against a
// Wishbone slave model and a word-list reference of the expected transfer.
`timescale 1ns/1ps
module tb_src_fetch;
    localparam int unsigned AW   = 32;
    localparam int unsigned LENW = 16;

    logic            wb_clk_i      = 1'b0;
    logic            wb_rst_i      = 1'b1;
    logic            start         = 1'b0;
    logic [AW-1:0]   src_addr      = '0;
    logic [LENW-1:0] src_len       = '0;
    logic            busy;
    logic            done;
    logic            err;
    logic [AW-1:0]   wbm_adr_o;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [7:0]      wbm_sel_o;
    logic [63:0]     wbm_dat_i     = '0;
    logic            wbm_ack_i     = 1'b0;
    logic            wbm_err_i     = 1'b0;
    logic            f_putn;
    logic [63:0]     f_dat;
    logic            f_last;
    logic            f_full        = 1'b0;
    logic            f_almost_full = 1'b0;

    src_fetch #(.AW(AW), .LENW(LENW)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .start         (start),
        .src_addr      (src_addr),
        .src_len       (src_len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .wbm_adr_o     (wbm_adr_o),
        .wbm_cyc_o     (wbm_cyc_o),
        .wbm_stb_o     (wbm_stb_o),
        .wbm_we_o      (wbm_we_o),
        .wbm_sel_o     (wbm_sel_o),
        .wbm_dat_i     (wbm_dat_i),
        .wbm_ack_i     (wbm_ack_i),
        .wbm_err_i     (wbm_err_i),
        .f_putn        (f_putn),
        .f_dat         (f_dat),
        .f_last        (f_last),
        .f_full        (f_full),
        .f_almost_full (f_almost_full)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    // Slave configuration and observations.
    int            cfg_lat      = 0;
    int            cfg_err_at   = -1;
    int            cfg_af_hold  = 0;
    bit            cfg_rand_af  = 1'b0;
    int            rd_idx       = 0;
    int            last_resp_cnt = -1;
    int            slave_viol   = 0;
    logic [AW-1:0] ack_adr_q[$];

    // Monitor observations.
    int            done_n = 0, done_at = -1, busy_n = 0, gap_n = 0, stb_n = 0;
    int            mon_viol = 0, first_stb_cnt = -1;
    logic          err_at_done = 1'b0;
    logic [64:0]   push_q[$];

    function automatic logic [63:0] word_at(input logic [AW-1:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wishbone slave: acks after cfg_lat wait cycles, errors on read index cfg_err_at.
    initial begin : slave
        int            wcnt;
        int            af_cnt;
        logic [AW-1:0] held;
        wcnt   = 0;
        af_cnt = 0;
        held   = '0;
        forever begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (wb_rst_i) begin
                wcnt          = 0;
                af_cnt        = 0;
                f_almost_full = 1'b0;
            end else begin
                if (af_cnt > 0) begin
                    f_almost_full = 1'b1;
                    af_cnt--;
                end else if (cfg_rand_af) begin
                    f_almost_full = ($urandom_range(0, 3) == 0);
                end else begin
                    f_almost_full = 1'b0;
                end
                if (wbm_cyc_o && wbm_stb_o) begin
                    if (wcnt == 0) held = wbm_adr_o;
                    else if (wbm_adr_o != held) slave_viol++;
                    if (wcnt >= cfg_lat) begin
                        wbm_ack_i = 1'b1;
                        wbm_err_i = (rd_idx == cfg_err_at);
                        wbm_dat_i = word_at(wbm_adr_o);
                        ack_adr_q.push_back(wbm_adr_o);
                        last_resp_cnt = cyc_cnt;
                        if (rd_idx == 0 && cfg_af_hold > 0) begin
                            f_almost_full = 1'b1;
                            af_cnt        = cfg_af_hold - 1;
                        end
                        rd_idx++;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_i) begin
                if (wbm_stb_o != wbm_cyc_o || wbm_we_o || wbm_sel_o != 8'hFF) mon_viol++;
                if (wbm_stb_o) begin
                    stb_n++;
                    if (first_stb_cnt < 0) first_stb_cnt = cyc_cnt;
                end
                if (!f_putn) begin
                    push_q.push_back({f_last, f_dat});
                    if (f_full) mon_viol++;
                end
                if (done) begin
                    done_n++;
                    done_at     = cyc_cnt;
                    err_at_done = err;
                end
                if (busy) busy_n++;
                if (busy && !wbm_cyc_o) gap_n++;
            end
        end
    end

    task automatic run_xfer(input logic [AW-1:0] addr, input int len, input int lat,
                            input int err_at, input int af_hold, input bit inject,
                            input int exp_pushes, input bit exp_err, input int exp_gap);
        logic [AW-1:0] base;
        logic [AW-1:0] ea;
        logic [64:0]   pw;
        int            n_rd;
        int            start_cnt;
        int            waited;
        int            exp_done;
        @(posedge wb_clk_i);
        #1;
        cfg_lat     = lat;
        cfg_err_at  = err_at;
        cfg_af_hold = af_hold;
        rd_idx      = 0;
        ack_adr_q.delete();
        push_q.delete();
        done_n = 0; done_at = -1; busy_n = 0; gap_n = 0; stb_n = 0;
        mon_viol = 0; slave_viol = 0; first_stb_cnt = -1; last_resp_cnt = -1;
        err_at_done = 1'b0;
        @(negedge wb_clk_i);
        start     = 1'b1;
        src_addr  = addr;
        src_len   = LENW'(len);
        start_cnt = cyc_cnt;
        @(negedge wb_clk_i);
        start = 1'b0;
        check("err_clear_on_start", err, 1'b0);
        check("busy_after_start", busy, (len != 0));
        if (inject) begin
            @(negedge wb_clk_i);
            start    = 1'b1;
            src_addr = 32'h0000_9000;
            src_len  = LENW'(7);
            @(negedge wb_clk_i);
            start = 1'b0;
        end
        waited = 0;
        while (done_n == 0 && waited < 2000) begin
            @(negedge wb_clk_i);
            waited++;
        end
        check("done_seen_in_time", (done_n != 0), 1'b1);
        repeat (3) @(negedge wb_clk_i);

        base = addr & ~AW'(7);
        n_rd = (err_at >= 0 && err_at < len) ? err_at + 1 : len;
        exp_done = (len == 0) ? start_cnt + 1 : last_resp_cnt + 1;
        check("done_pulses", done_n, 1);
        check("done_timing", done_at, exp_done);
        if (len != 0 && !cfg_rand_af) check("first_stb_timing", first_stb_cnt, start_cnt + 1);
        if (len == 0) check("no_stb_for_len0", stb_n, 0);
        check("busy_cycles", busy_n, done_at - start_cnt - 1);
        check("err_at_done", err_at_done, exp_err);
        check("err_held", err, exp_err);
        check("read_count", ack_adr_q.size(), n_rd);
        for (int i = 0; i < n_rd && i < ack_adr_q.size(); i++) begin
            ea = base + AW'(i) * AW'(8);
            check("read_addr", ack_adr_q[i], ea);
        end
        check("push_count", push_q.size(), exp_pushes);
        for (int i = 0; i < exp_pushes && i < push_q.size(); i++) begin
            ea = base + AW'(i) * AW'(8);
            pw = {(i == len - 1), word_at(ea)};
            check("push_last_and_data", push_q[i], pw);
        end
        if (exp_gap >= 0) check("hold_gap_cycles", gap_n, exp_gap);
        check("protocol_violations", mon_viol + slave_viol, 0);
        check("idle_after_done", {busy, wbm_cyc_o, f_putn}, 3'b001);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        int            lat;
        int            err_at;
        int            af_hold;
        bit            inject;
        int            exp_pushes;
        bit            exp_err;
        int            exp_gap;
    } vec_t;

    function automatic vec_t mk(input logic [AW-1:0] addr, input int len, input int lat,
                                input int err_at, input int af_hold, input bit inject,
                                input int exp_pushes, input bit exp_err, input int exp_gap);
        vec_t v;
        v.addr = addr; v.len = len; v.lat = lat; v.err_at = err_at; v.af_hold = af_hold;
        v.inject = inject; v.exp_pushes = exp_pushes; v.exp_err = exp_err; v.exp_gap = exp_gap;
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t          vecs[11];
        logic [AW-1:0] r_addr;
        int            r_len, r_err_at, waited;

        vecs[0]  = mk(32'h0000_1000, 4, 1, -1, 0, 1'b0, 4, 1'b0, 0);
        vecs[1]  = mk(32'h0000_1000, 4, 0, -1, 0, 1'b0, 4, 1'b0, 0);
        vecs[2]  = mk(32'h0000_3000, 3, 0, -1, 5, 1'b0, 3, 1'b0, 5);
        vecs[3]  = mk(32'h0000_4000, 4, 1,  1, 0, 1'b0, 1, 1'b1, 0);
        vecs[4]  = mk(32'h0000_2000, 0, 0, -1, 0, 1'b0, 0, 1'b0, 0);
        vecs[5]  = mk(32'h0000_4100, 2, 0, -1, 0, 1'b0, 2, 1'b0, 0);
        vecs[6]  = mk(32'hFFFF_FFF8, 2, 0, -1, 0, 1'b0, 2, 1'b0, 0);
        vecs[7]  = mk(32'h0000_1003, 2, 2, -1, 0, 1'b0, 2, 1'b0, 0);
        vecs[8]  = mk(32'h0000_5000, 3, 1,  0, 0, 1'b0, 0, 1'b1, 0);
        vecs[9]  = mk(32'h0000_5100, 2, 0,  1, 0, 1'b0, 1, 1'b1, 0);
        vecs[10] = mk(32'h0000_8000, 3, 2, -1, 0, 1'b1, 3, 1'b0, 0);

        repeat (3) @(negedge wb_clk_i);
        check("reset_ctrl", {busy, done, err, wbm_cyc_o, wbm_stb_o, f_last, f_putn}, 7'b0000001);
        check("reset_adr", wbm_adr_o, '0);
        check("reset_dat", f_dat, '0);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        for (int i = 0; i < 11; i++) begin
            run_xfer(vecs[i].addr, vecs[i].len, vecs[i].lat, vecs[i].err_at, vecs[i].af_hold,
                     vecs[i].inject, vecs[i].exp_pushes, vecs[i].exp_err, vecs[i].exp_gap);
        end

        // Reset in the middle of a back-to-back burst, then a fresh transfer.
        @(posedge wb_clk_i);
        #1;
        cfg_lat = 0; cfg_err_at = -1; cfg_af_hold = 0; rd_idx = 0;
        @(negedge wb_clk_i);
        start = 1'b1; src_addr = 32'h0000_6000; src_len = LENW'(8);
        @(negedge wb_clk_i);
        start = 1'b0;
        waited = 0;
        while (!wbm_stb_o && waited < 20) begin
            @(negedge wb_clk_i);
            waited++;
        end
        repeat (2) @(negedge wb_clk_i);
        check("stb_before_reset", wbm_stb_o, 1'b1);
        wb_rst_i = 1'b1;
        #1;
        check("midreset_ctrl", {busy, done, err, wbm_cyc_o, wbm_stb_o, f_last, f_putn},
              7'b0000001);
        check("midreset_adr", wbm_adr_o, '0);
        check("midreset_dat", f_dat, '0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        run_xfer(32'h0000_7010, 3, 1, -1, 0, 1'b0, 3, 1'b0, 0);

        // Randomized transfers with FIFO back-pressure toggling.
        cfg_rand_af = 1'b1;
        for (int i = 0; i < 25; i++) begin
            r_addr   = $urandom;
            r_len    = $urandom_range(0, 6);
            r_err_at = -1;
            if (r_len > 0 && $urandom_range(0, 3) == 0) r_err_at = $urandom_range(0, r_len - 1);
            run_xfer(r_addr, r_len, $urandom_range(0, 2), r_err_at, 0, 1'b0,
                     (r_err_at >= 0) ? r_err_at : r_len, (r_err_at >= 0), -1);
        end
        cfg_rand_af = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
